// File: rtl/ib_ctrl.sv
// Input-buffer controller for one router input port: requests the head flit's
// output, pops whole packets after grant, and discards bad-dest and orphan flits.
//
// state | meaning
// IDLE  | evaluating the head flit at the FIFO output
// REQ   | request raised, head still in FIFO, waiting for grant
// XFER  | granted, popping flits until the tail is consumed
// DROP  | popping a bad-destination packet until its tail
module ib_ctrl #(
    parameter int FLIT_W = 10,
    parameter int NPORTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] pkto,
    input  logic              empty,
    output logic              re,
    output logic [NPORTS-1:0] req,
    input  logic              gnt,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int DEST_W = ($clog2(NPORTS) > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        XFER = 4'b0100,
        DROP = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic [NPORTS-1:0] req_q, req_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]        drop_sat;
    logic [NPORTS-1:0] dest_onehot;
    logic [DEST_W-1:0] dest;
    logic              is_head;
    logic              is_tail;
    logic              dest_ok;
    logic              re_int;
    logic              unused_mid;

    assign is_head    = pkto[FLIT_W-1];
    assign is_tail    = pkto[FLIT_W-2];
    assign dest       = pkto[DEST_W-1:0];
    assign dest_ok    = {{(32-DEST_W){1'b0}}, dest} < 32'(NPORTS);
    assign drop_sat   = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    assign unused_mid = ^pkto[FLIT_W-3:DEST_W];

    always_comb begin
        dest_onehot = '0;
        for (int i = 0; i < NPORTS; i++) begin
            dest_onehot[i] = (dest == DEST_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        drop_cnt_d = drop_cnt_q;
        re_int     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (is_head) begin
                        if (dest_ok) begin
                            state_d = REQ;
                            req_d   = dest_onehot;
                        end else begin
                            state_d    = DROP;
                            drop_cnt_d = drop_sat;
                        end
                    end else begin
                        // orphan body/tail: pop and count, stay in IDLE
                        re_int     = 1'b1;
                        drop_cnt_d = drop_sat;
                    end
                end
            end
            REQ: begin
                if (gnt) state_d = XFER;
            end
            XFER: begin
                re_int = !empty;
                if (!empty && is_tail) begin
                    state_d = IDLE;
                    req_d   = '0;
                end
            end
            DROP: begin
                re_int = !empty;
                if (!empty && is_tail) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign re       = rst & re_int;
    assign busy     = rst & (state_q != IDLE);
    assign req      = req_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ib_ctrl.sv
// Bench for ib_ctrl (NPORTS=3): a FIFO model feeds the DUT, a packet-level
// reference model predicts every pop and the drop count.
module tb_ib_ctrl;

    typedef struct packed {
        logic [9:0] flit;
        logic [2:0] req;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pkto = 10'd0;
    logic       empty = 1'b1;
    logic       re;
    logic [2:0] req;
    logic       gnt = 1'b0;
    logic       busy;
    logic [7:0] drop_cnt;

    logic [9:0] fifo[$];
    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_drop = 0;
    int         m_mode = 0;      // 0 between packets, 1 forwarding, 2 dropping
    logic [2:0] m_req = 3'd0;
    int         gnt_mode = 0;    // 0 manual, 1 always, 2 random-and-hold
    logic       gnt_man = 1'b0;
    logic       stall_en = 1'b0;
    logic       re_s = 1'b0;

    ib_ctrl #(.FLIT_W(10), .NPORTS(3)) dut (
        .clk(clk), .rst(rst), .pkto(pkto), .empty(empty), .re(re),
        .req(req), .gnt(gnt), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, x, $time);
        end
    endfunction

    function automatic void drop_one();
        if (exp_drop < 255) exp_drop++;
    endfunction

    // Packet-level rules: a head with a legal dest forwards its packet with
    // one-hot(dest) held; an illegal dest drops the packet; a non-head flit
    // outside a packet is an orphan.
    function automatic void model_push(input logic [9:0] f);
        logic head, tail;
        int   dest;
        head = f[9];
        tail = f[8];
        dest = int'(f[1:0]);
        if (m_mode == 0) begin
            if (!head) begin
                drop_one();
                exp_q.push_back({f, 3'b000});
            end else if (dest < 3) begin
                m_req = 3'(1 << dest);
                exp_q.push_back({f, m_req});
                if (!tail) m_mode = 1;
            end else begin
                drop_one();
                exp_q.push_back({f, 3'b000});
                if (!tail) m_mode = 2;
            end
        end else begin
            exp_q.push_back({f, (m_mode == 1) ? m_req : 3'b000});
            if (tail) m_mode = 0;
        end
    endfunction

    function automatic logic [9:0] mk(input logic [1:0] t, input logic [1:0] d);
        return {t, 6'($urandom), d};
    endfunction

    task automatic push(input logic [9:0] f);
        fifo.push_back(f);
        model_push(f);
    endtask

    task automatic cyc();
        @(negedge clk);
        #4;
    endtask

    task automatic step_chk(input string tag, input logic [2:0] r, input logic e, input logic b);
        cyc();
        chk({tag, "_req"}, 32'(req), 32'(r));
        chk({tag, "_re"}, 32'(re), 32'(e));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (fifo.size() == 0 && exp_q.size() == 0 && !busy) break;
            cyc();
        end
        chk("drain_in_budget", 32'(i < budget), 32'd1);
    endtask

    task automatic gen_pkt();
        int k;
        int nb;
        k  = $urandom_range(0, 9);
        nb = $urandom_range(0, 3);
        if (k <= 4) begin
            push(mk(2'b10, 2'($urandom_range(0, 2))));
            repeat (nb) push(mk(2'b00, 2'($urandom)));
            push(mk(2'b01, 2'($urandom)));
        end else if (k <= 6) begin
            push(mk(2'b11, 2'($urandom)));
        end else if (k == 7) begin
            push(mk(2'b10, 2'd3));
            repeat (nb) push(mk(2'b00, 2'($urandom)));
            push(mk(2'b01, 2'($urandom)));
        end else begin
            push(mk(($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00, 2'($urandom)));
        end
    endtask

    initial begin
        logic [9:0] junk;
        exp_t       e;

        fork
            forever begin  // FIFO front end and arbiter model
                @(negedge clk);
                #1;
                case (gnt_mode)
                    0: gnt = gnt_man;
                    1: gnt = 1'b1;
                    default: begin
                        if (req == 3'd0) gnt = 1'b0;
                        else if (!gnt) gnt = ($urandom_range(0, 2) == 0);
                    end
                endcase
                if (fifo.size() == 0 || (stall_en && $urandom_range(0, 3) == 0)) begin
                    empty = 1'b1;
                    pkto  = 10'($urandom);
                end else begin
                    empty = 1'b0;
                    pkto  = fifo[0];
                end
            end
            forever begin  // monitor: every pop is matched against the scoreboard
                @(negedge clk);
                #3;
                re_s = re;
                if (rst && re) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop got=%0h exp=none at %0t", pkto, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_flit", 32'(pkto), 32'(e.flit));
                        chk("pop_req", 32'(req), 32'(e.req));
                    end
                end
            end
            forever begin
                @(posedge clk);
                if (re_s && fifo.size() > 0) junk = fifo.pop_front();
            end
            begin
                #500000;
                $display("FAIL watchdog got=timeout exp=finish");
                $fatal(1);
            end
        join_none

        // reset state, with an orphan already waiting at the FIFO output
        push(mk(2'b00, 2'd0));
        cyc();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk); #2; rst = 1'b1;
        drain(20);
        chk("orphan_after_rst_drop", 32'(drop_cnt), 32'(exp_drop));

        // single packet, grant raised late
        gnt_mode = 0;
        gnt_man  = 1'b0;
        push(mk(2'b10, 2'd2));
        push(mk(2'b00, 2'($urandom)));
        push(mk(2'b01, 2'($urandom)));
        step_chk("single1", 3'b000, 1'b0, 1'b0);
        step_chk("single2", 3'b100, 1'b0, 1'b1);
        step_chk("single3", 3'b100, 1'b0, 1'b1);
        step_chk("single4", 3'b100, 1'b0, 1'b1);
        gnt_man = 1'b1;
        step_chk("single5", 3'b100, 1'b0, 1'b1);
        step_chk("single6", 3'b100, 1'b1, 1'b1);
        step_chk("single7", 3'b100, 1'b1, 1'b1);
        step_chk("single8", 3'b100, 1'b1, 1'b1);
        step_chk("single9", 3'b000, 1'b0, 1'b0);
        gnt_man = 1'b0;
        chk("single_drop", 32'(drop_cnt), 32'(exp_drop));

        // FIFO runs dry mid-packet
        gnt_mode = 1;
        push(mk(2'b10, 2'd1));
        push(mk(2'b00, 2'($urandom)));
        step_chk("stall1", 3'b000, 1'b0, 1'b0);
        step_chk("stall2", 3'b010, 1'b0, 1'b1);
        step_chk("stall3", 3'b010, 1'b1, 1'b1);
        step_chk("stall4", 3'b010, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step_chk("stall_gap", 3'b010, 1'b0, 1'b1);
        push(mk(2'b01, 2'($urandom)));
        step_chk("stall9", 3'b010, 1'b1, 1'b1);
        step_chk("stall10", 3'b000, 1'b0, 1'b0);

        // back-to-back single-flit packets
        push(mk(2'b11, 2'd2));
        push(mk(2'b11, 2'd0));
        step_chk("ht1", 3'b000, 1'b0, 1'b0);
        step_chk("ht2", 3'b100, 1'b0, 1'b1);
        step_chk("ht3", 3'b100, 1'b1, 1'b1);
        step_chk("ht4", 3'b000, 1'b0, 1'b0);
        step_chk("ht5", 3'b001, 1'b0, 1'b1);
        step_chk("ht6", 3'b001, 1'b1, 1'b1);
        step_chk("ht7", 3'b000, 1'b0, 1'b0);

        // out-of-range destination
        push(mk(2'b10, 2'd3));
        push(mk(2'b00, 2'($urandom)));
        push(mk(2'b00, 2'($urandom)));
        push(mk(2'b01, 2'($urandom)));
        step_chk("bad1", 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_chk("bad_pop", 3'b000, 1'b1, 1'b1);
        step_chk("bad6", 3'b000, 1'b0, 1'b0);
        chk("bad_drop", 32'(drop_cnt), 32'(exp_drop));

        // orphan stream drives the counter into saturation
        for (int i = 0; i < 260; i++) push(mk(2'b00, 2'($urandom)));
        for (int i = 0; i < 260; i++) step_chk("orph", 3'b000, 1'b1, 1'b0);
        step_chk("orph_end", 3'b000, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("sat_drop_ff", 32'(drop_cnt), 32'hFF);

        // async reset in the middle of a transfer
        push(mk(2'b10, 2'd0));
        push(mk(2'b00, 2'($urandom)));
        step_chk("arst1", 3'b000, 1'b0, 1'b0);
        step_chk("arst2", 3'b001, 1'b0, 1'b1);
        step_chk("arst3", 3'b001, 1'b1, 1'b1);
        @(posedge clk); #2; rst = 1'b0;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_re", 32'(re), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        exp_q.delete();
        m_mode   = 0;
        exp_drop = 0;
        foreach (fifo[i]) model_push(fifo[i]);
        cyc();
        cyc();
        @(posedge clk); #2; rst = 1'b1;
        drain(20);
        chk("arst_orphan_drop", 32'(drop_cnt), 32'd1);

        // randomized traffic with FIFO stalls and random grant latency
        stall_en = 1'b1;
        gnt_mode = 2;
        for (int p = 0; p < 40; p++) begin
            gen_pkt();
            repeat ($urandom_range(0, 4)) cyc();
        end
        drain(4000);
        chk("rand_drop", 32'(drop_cnt), 32'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
